spi_chan_regfile: RTL and testbench
===================================

Name: spi_chan_regfile

Overview:
Parametrised successor to the single-channel SPI keyboard/config slave. Provides an SPI-mode-0 register file for NCH tracking channels: per-channel satellite, Doppler, PWM and enable settings, plus readback of per-channel tracker status. It sits between the external controller and the array of CA/Doppler tracker channels in the top level.

Parameters:
NCH, 4, number of tracker channels (1..15)
SAT_W, 5, satellite select width
DOP_W, 12, Doppler set / iffreq width
PWM_W, 10, PWM set / pwmvalue width
ID_CODE, 8'hA1, block identifier returned at address 0x7F

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
SCK  in  1  SPI clock (asynchronous to clk; f_SCK <= f_clk/8)
SSEL  in  1  SPI select, active-low
MOSI  in  1  SPI data in
MISO  out  1  SPI data out
satset  out  NCH*SAT_W  per-channel satellite select, ch0 in LSBs
dopset  out  NCH*DOP_W  per-channel Doppler setting
pwmset  out  NCH*PWM_W  per-channel PWM setting
chen  out  NCH  per-channel enable
iffreq  in  NCH*DOP_W  per-channel measured IF frequency (read-only status)
pwmvalue  in  NCH*PWM_W  per-channel PWM value (read-only status)
wr_stb  out  1  one-clk pulse on every committed write
wr_addr  out  7  address of last committed write

Behaviour:
- Reset: satset ch k = k+1; dopset = 12'h800; pwmset = 10'h200; chen = 0; MISO = 0; wr_stb = 0; wr_addr = 0; FSM = IDLE; synchronisers cleared. Reset mid-frame aborts the frame with no write.
- SCK, SSEL, MOSI each pass through a 2-FF synchroniser plus one history FF. SCK rise/fall are detected in clk domain. MOSI is sampled on SCK rise; MISO updates on SCK fall.
- Frame: 24 bits, MSB first. Bit 23 = W (1 = write, 0 = read). Bits 22:16 = addr[6:0]. Bits 15:0 = data.
- Address map: ch = addr[6:3], reg = addr[2:0].
  - reg0 satset (RW)
  - reg1 dopset (RW)
  - reg2 pwmset (RW)
  - reg3 chen, bit0 (RW)
  - reg4 iffreq (RO)
  - reg5 pwmvalue (RO)
  - reg6/7 read 0
  - addr 0x7F reads {NCH[7:0], ID_CODE}.
  - Channels >= NCH read 0; writes to them are ignored.
  - Read data is zero-extended to 16 bits. On write, only the low field bits are stored.
- FSM states:
  - IDLE: SSEL high.
  - SSEL fall -> CMD: bit counter = 0.
  - After 8th SCK rise -> DATA: latch W and addr. On the same clk, if read, load the 16-bit shift-out register with the addressed value. RO inputs are snapshotted at this clk.
  - After 24th SCK rise -> DONE: if W, commit data. wr_stb is high for exactly 1 clk, 1 clk after the 24th rise is detected. wr_addr is updated.
  - DONE ignores further SCK edges; there are no auto-increment and no second write.
  - SSEL rise in any state -> IDLE. If fewer than 24 bits were received, no write occurs.
- MISO:
  - 0 in IDLE, CMD and DONE, and throughout write frames.
  - In a read frame, bit 15 of the snapshot is driven from the 8th SCK fall onward. Each subsequent fall shifts left, so the host samples data bit 15-i on rise 9+i.
- Write and status-input change in the same clk: the write wins for RW regs. RO regs are never written (write strobe still pulses, wr_addr updated).
- Bit counter saturates at 24; no wrap.
- SSEL deassert and SCK edge in the same clk: SSEL takes priority.

Test Plan:
- Reset -> satset = {5'd4,5'd3,5'd2,5'd1} (NCH=4); dopset each 0x800; pwmset each 0x200; chen = 0; MISO = 0.
- Write frame W=1 addr 0x10 data 0x0007 -> satset ch2 = 7; wr_stb single 1-clk pulse; wr_addr = 0x10; other channels unchanged. Read frame addr 0x10 -> MISO shifts 0x0007.
- iffreq ch1 = 0xABC, read addr 0x0C -> MISO returns 0x0ABC. Change iffreq to 0x123 during data phase -> still 0xABC (snapshot).
- Read addr 0x7F -> 0x04A1. Read addr 0x28 (ch5 >= NCH) -> 0x0000. Write 0x28 -> no output change; wr_stb still pulses.
- Write frame addr 0x01 aborted by SSEL high after 20 bits -> dopset ch0 stays 0x800, no wr_stb. Next full frame works normally.
- Assert rst mid-read at bit 12 -> all outputs at reset values, MISO = 0. Frame after release decodes correctly. 30-bit frame -> exactly one write.

Source files
------------

// File: rtl/spi_chan_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_chan_regfile_if
//  Brief    : SPI mode-0 bus bundle (SCK/SSEL/MOSI from host, MISO to host)
//  Revision : 1.0  initial release
// ============================================================================
interface spi_chan_regfile_if;
  logic SCK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  // Host side drives clock, select and data-out
  modport master (output SCK, output SSEL, output MOSI, input MISO);
  // Register-file side
  modport slave  (input SCK, input SSEL, input MOSI, output MISO);
endinterface
`default_nettype wire

// File: rtl/spi_chan_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : spi_chan_regfile
//  Brief    : SPI mode-0 slave register file for NCH tracker channels.
//             24-bit frames {W, addr[6:0], data[15:0]}, MSB first.
//             addr[6:3] = channel, addr[2:0] = register; 0x7F = ID word.
//  Revision : 1.0  initial release
// ============================================================================
module spi_chan_regfile #(
  parameter int          NCH     = 4,
  parameter int          SAT_W   = 5,
  parameter int          DOP_W   = 12,
  parameter int          PWM_W   = 10,
  parameter logic [7:0]  ID_CODE = 8'hA1
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  spi_chan_regfile_if.slave           spi,
  output      logic [NCH*SAT_W-1:0]   satset,
  output      logic [NCH*DOP_W-1:0]   dopset,
  output      logic [NCH*PWM_W-1:0]   pwmset,
  output      logic [NCH-1:0]         chen,
  input  wire logic [NCH*DOP_W-1:0]   iffreq,
  input  wire logic [NCH*PWM_W-1:0]   pwmvalue,
  output      logic                   wr_stb,
  output      logic [6:0]             wr_addr
);

  localparam logic [4:0] c_cmd_last   = 5'd7;
  localparam logic [4:0] c_frame_last = 5'd23;
  localparam logic [4:0] c_frame_bits = 5'd24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // synchroniser and edge-history flops
  logic r_sck_s1,  r_sck_s2,  r_sck_h;
  logic r_ssel_s1, r_ssel_s2, r_ssel_h;
  logic r_mosi_s1, r_mosi_s2, r_mosi_h;

  logic w_sck_rise, w_sck_fall, w_ssel_fall, w_ssel_rise;
  logic w_cmd_done, w_frame_done, w_shift_en, w_start, w_commit;

  // frame datapath
  logic [4:0]  r_bitcnt;
  logic [14:0] r_shift;
  logic        r_w;
  logic [6:0]  r_addr;
  logic [15:0] r_shift_out;
  logic        r_miso;
  logic        r_wr_stb;
  logic [6:0]  r_wr_addr;

  logic [6:0]  w_cmd_addr;
  logic [15:0] w_rd_data;
  logic [15:0] w_frame_data;
  logic [3:0]  w_wr_ch;
  logic [2:0]  w_wr_reg;

  // register file
  logic [SAT_W-1:0] r_sat [NCH];
  logic [DOP_W-1:0] r_dop [NCH];
  logic [PWM_W-1:0] r_pwm [NCH];
  logic [NCH-1:0]   r_chen;

  // Bring the three SPI inputs into the clk domain and keep one history stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s1  <= 1'b0; r_sck_s2  <= 1'b0; r_sck_h  <= 1'b0;
      r_ssel_s1 <= 1'b0; r_ssel_s2 <= 1'b0; r_ssel_h <= 1'b0;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0; r_mosi_h <= 1'b0;
    end else begin
      r_sck_s1  <= spi.SCK;  r_sck_s2  <= r_sck_s1;  r_sck_h  <= r_sck_s2;
      r_ssel_s1 <= spi.SSEL; r_ssel_s2 <= r_ssel_s1; r_ssel_h <= r_ssel_s2;
      r_mosi_s1 <= spi.MOSI; r_mosi_s2 <= r_mosi_s1; r_mosi_h <= r_mosi_s2;
    end
  end

  assign w_sck_rise  =  r_sck_s2  & ~r_sck_h;
  assign w_sck_fall  = ~r_sck_s2  &  r_sck_h;
  assign w_ssel_rise =  r_ssel_s2 & ~r_ssel_h;
  assign w_ssel_fall = ~r_ssel_s2 &  r_ssel_h;

  // MOSI is taken from the history stage: one clk older than the detected
  // SCK rise, still well inside the half-period the host holds it stable.
  assign w_cmd_addr   = {r_shift[5:0], r_mosi_h};
  assign w_frame_data = {r_shift[14:0], r_mosi_h};
  assign w_wr_ch      = r_addr[6:3];
  assign w_wr_reg     = r_addr[2:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; SSEL deassertion outranks any SCK edge in the same clk
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_done   = 1'b0;
    w_frame_done = 1'b0;
    w_start      = 1'b0;
    if (w_ssel_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ssel_fall) begin
            w_state_nxt = S_CMD;
            w_start     = 1'b1;
          end
        end
        S_CMD: begin
          if (w_sck_rise && r_bitcnt == c_cmd_last) begin
            w_state_nxt = S_DATA;
            w_cmd_done  = 1'b1;
          end
        end
        S_DATA: begin
          if (w_sck_rise && r_bitcnt == c_frame_last) begin
            w_state_nxt  = S_DONE;
            w_frame_done = 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_shift_en = w_sck_rise & ~w_ssel_rise &
                      (r_state == S_CMD || r_state == S_DATA);
  assign w_commit   = w_frame_done & r_w;

  // Read mux: addressed value for the command just received (zero-extended)
  always_comb begin
    w_rd_data = 16'h0000;
    if (w_cmd_addr == 7'h7F) begin
      w_rd_data = {8'(NCH), ID_CODE};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_cmd_addr[6:3] == 4'(k)) begin
          case (w_cmd_addr[2:0])
            3'd0:    w_rd_data = 16'(r_sat[k]);
            3'd1:    w_rd_data = 16'(r_dop[k]);
            3'd2:    w_rd_data = 16'(r_pwm[k]);
            3'd3:    w_rd_data = {15'd0, r_chen[k]};
            3'd4:    w_rd_data = 16'(iffreq[k*DOP_W +: DOP_W]);
            3'd5:    w_rd_data = 16'(pwmvalue[k*PWM_W +: PWM_W]);
            default: w_rd_data = 16'h0000;
          endcase
        end
      end
    end
  end

  // Frame datapath: bit counter, shift-in, command latch, shift-out, strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt    <= 5'd0;
      r_shift     <= 15'd0;
      r_w         <= 1'b0;
      r_addr      <= 7'd0;
      r_shift_out <= 16'h0000;
      r_miso      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= 7'd0;
    end else begin
      r_wr_stb <= 1'b0;

      if (w_start) begin
        r_bitcnt <= 5'd0;
      end else if (w_shift_en) begin
        r_bitcnt <= (r_bitcnt == c_frame_bits) ? r_bitcnt : r_bitcnt + 5'd1;
        r_shift  <= {r_shift[13:0], r_mosi_h};
      end

      // Status inputs are frozen here, at the clk that closes the command byte
      if (w_cmd_done) begin
        r_w         <= r_shift[6];
        r_addr      <= w_cmd_addr;
        r_shift_out <= r_shift[6] ? 16'h0000 : w_rd_data;
      end else if (r_state == S_DATA && !r_w && w_sck_fall && !w_ssel_rise) begin
        r_shift_out <= {r_shift_out[14:0], 1'b0};
      end

      // MISO only carries data inside a read frame's data phase
      if (r_state == S_DATA && !r_w && !w_ssel_rise) begin
        if (w_sck_fall) r_miso <= r_shift_out[15];
      end else begin
        r_miso <= 1'b0;
      end

      if (w_commit) begin
        r_wr_stb  <= 1'b1;
        r_wr_addr <= r_addr;
      end
    end
  end

  // Channel register file; only the low field bits of the data word are kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_sat[k] <= SAT_W'(k + 1);
        r_dop[k] <= DOP_W'(12'h800);
        r_pwm[k] <= PWM_W'(10'h200);
      end
      r_chen <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr_ch == 4'(k)) begin
          case (w_wr_reg)
            3'd0:    r_sat[k]  <= w_frame_data[SAT_W-1:0];
            3'd1:    r_dop[k]  <= w_frame_data[DOP_W-1:0];
            3'd2:    r_pwm[k]  <= w_frame_data[PWM_W-1:0];
            3'd3:    r_chen[k] <= w_frame_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign satset[k*SAT_W +: SAT_W] = r_sat[k];
    assign dopset[k*DOP_W +: DOP_W] = r_dop[k];
    assign pwmset[k*PWM_W +: PWM_W] = r_pwm[k];
  end

  assign chen     = r_chen;
  assign spi.MISO = r_miso;
  assign wr_stb   = r_wr_stb;
  assign wr_addr  = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_chan_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_chan_regfile
//  Brief    : Self-checking bench for spi_chan_regfile (NCH=4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_chan_regfile;

  localparam int NCH   = 4;
  localparam int SAT_W = 5;
  localparam int DOP_W = 12;
  localparam int PWM_W = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*SAT_W-1:0]  satset;
  logic [NCH*DOP_W-1:0]  dopset;
  logic [NCH*PWM_W-1:0]  pwmset;
  logic [NCH-1:0]        chen;
  logic [NCH*DOP_W-1:0]  iffreq;
  logic [NCH*PWM_W-1:0]  pwmvalue;
  logic                  wr_stb;
  logic [6:0]            wr_addr;

  spi_chan_regfile_if spi_if ();

  spi_chan_regfile #(
    .NCH(NCH), .SAT_W(SAT_W), .DOP_W(DOP_W), .PWM_W(PWM_W), .ID_CODE(8'hA1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi_if),
    .satset   (satset),
    .dopset   (dopset),
    .pwmset   (pwmset),
    .chen     (chen),
    .iffreq   (iffreq),
    .pwmvalue (pwmvalue),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;

  // Count every clk in which the write strobe is high
  always @(negedge clk) if (wr_stb === 1'b1) stb_cnt++;

  // ---------------- reference model (channel arrays, spec arithmetic) -----
  int m_sat [NCH];
  int m_dop [NCH];
  int m_pwm [NCH];
  int m_chen[NCH];
  int m_wr_addr;

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_sat[k] = k + 1; m_dop[k] = 'h800; m_pwm[k] = 'h200; m_chen[k] = 0;
    end
    m_wr_addr = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    int ch, rg;
    ch = a / 8; rg = a % 8;
    m_wr_addr = a;
    if (ch < NCH) begin
      case (rg)
        0: m_sat[ch]  = d % (1 << SAT_W);
        1: m_dop[ch]  = d % (1 << DOP_W);
        2: m_pwm[ch]  = d % (1 << PWM_W);
        3: m_chen[ch] = d % 2;
        default: ;
      endcase
    end
  endfunction

  function automatic int model_read(input int a);
    int ch, rg;
    ch = a / 8; rg = a % 8;
    if (a == 'h7F) return NCH * 256 + 'hA1;
    if (ch >= NCH) return 0;
    case (rg)
      0: return m_sat[ch];
      1: return m_dop[ch];
      2: return m_pwm[ch];
      3: return m_chen[ch];
      4: return int'(iffreq[ch*DOP_W +: DOP_W]);
      5: return int'(pwmvalue[ch*PWM_W +: PWM_W]);
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] es, ed, ep, ec;
    es = 0; ed = 0; ep = 0; ec = 0;
    for (int k = 0; k < NCH; k++) begin
      es = es | (64'(m_sat[k]) << (k*SAT_W));
      ed = ed | (64'(m_dop[k]) << (k*DOP_W));
      ep = ep | (64'(m_pwm[k]) << (k*PWM_W));
      ec = ec | (64'(m_chen[k]) << k);
    end
    check({tag, ".satset"}, 64'(satset), es);
    check({tag, ".dopset"}, 64'(dopset), ed);
    check({tag, ".pwmset"}, 64'(pwmset), ep);
    check({tag, ".chen"},   64'(chen),   ec);
    check({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
  endtask

  // ---------------- SPI host ----------------------------------------------
  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic w, input logic [6:0] a, input logic [15:0] d,
                          input int nbits, input bit release_ssel,
                          output logic [15:0] rd);
    logic [23:0] fr;
    fr = {w, a, d};
    rd = 16'h0000;
    spi_if.SSEL = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      spi_if.MOSI = (i < 24) ? fr[23-i] : 1'b0;
      half();
      if (i >= 8 && i < 24) rd[23-i] = spi_if.MISO;
      spi_if.SCK = 1'b1;
      half();
      spi_if.SCK = 1'b0;
    end
    half();
    if (release_ssel) begin
      spi_if.SSEL = 1'b1;
      half();
      half();
    end
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    int          exp_stb;
  } vec_t;

  vec_t tbl[16];
  logic [15:0] rd;
  int s0;

  initial begin
    rst = 1'b1;
    spi_if.SCK = 1'b0; spi_if.SSEL = 1'b1; spi_if.MOSI = 1'b0;
    iffreq = '0; pwmvalue = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Reset state
    model_reset();
    check("reset.satset", 64'(satset), 64'({5'd4, 5'd3, 5'd2, 5'd1}));
    check("reset.dopset", 64'(dopset), 64'({12'h800, 12'h800, 12'h800, 12'h800}));
    check("reset.pwmset", 64'(pwmset), 64'({10'h200, 10'h200, 10'h200, 10'h200}));
    check("reset.chen",   64'(chen), 64'd0);
    check("reset.miso",   64'(spi_if.MISO), 64'd0);
    check("reset.wr_stb", 64'(wr_stb), 64'd0);
    check("reset.wr_addr", 64'(wr_addr), 64'd0);

    iffreq[1*DOP_W +: DOP_W]   = 12'hABC;
    iffreq[2*DOP_W +: DOP_W]   = 12'h321;
    pwmvalue[1*PWM_W +: PWM_W] = 10'h155;

    // Directed vector table
    tbl[0]  = '{1'b1, 7'h10, 16'h0007, 16'h0000, 1};
    tbl[1]  = '{1'b0, 7'h10, 16'h0000, 16'h0007, 0};
    tbl[2]  = '{1'b0, 7'h7F, 16'h0000, 16'h04A1, 0};
    tbl[3]  = '{1'b0, 7'h28, 16'h0000, 16'h0000, 0};
    tbl[4]  = '{1'b1, 7'h28, 16'hFFFF, 16'h0000, 1};
    tbl[5]  = '{1'b0, 7'h0C, 16'h0000, 16'h0ABC, 0};
    tbl[6]  = '{1'b1, 7'h0B, 16'hFFFF, 16'h0000, 1};
    tbl[7]  = '{1'b0, 7'h0B, 16'h0000, 16'h0001, 0};
    tbl[8]  = '{1'b1, 7'h19, 16'hFFFF, 16'h0000, 1};
    tbl[9]  = '{1'b0, 7'h19, 16'h0000, 16'h0FFF, 0};
    tbl[10] = '{1'b0, 7'h0D, 16'h0000, 16'h0155, 0};
    tbl[11] = '{1'b0, 7'h1E, 16'h0000, 16'h0000, 0};
    tbl[12] = '{1'b1, 7'h14, 16'h1234, 16'h0000, 1};
    tbl[13] = '{1'b0, 7'h14, 16'h0000, 16'h0321, 0};
    tbl[14] = '{1'b0, 7'h02, 16'h0000, 16'h0200, 0};
    tbl[15] = '{1'b0, 7'h18, 16'h0000, 16'h0004, 0};

    for (int i = 0; i < 16; i++) begin
      s0 = stb_cnt;
      spi_xfer(tbl[i].w, tbl[i].addr, tbl[i].data, 24, 1'b1, rd);
      if (tbl[i].w) model_write(int'(tbl[i].addr), int'(tbl[i].data));
      check($sformatf("tbl%0d.rd", i), 64'(rd), 64'(tbl[i].exp_rd));
      check($sformatf("tbl%0d.stb", i), 64'(stb_cnt - s0), 64'(tbl[i].exp_stb));
      check_outputs($sformatf("tbl%0d", i));
    end

    // Snapshot: iffreq changes during the data phase, read returns old value
    iffreq[1*DOP_W +: DOP_W] = 12'hABC;
    fork
      spi_xfer(1'b0, 7'h0C, 16'h0000, 24, 1'b1, rd);
      begin
        repeat (200) @(negedge clk);
        iffreq[1*DOP_W +: DOP_W] = 12'h123;
      end
    join
    check("snap.old", 64'(rd), 64'h0ABC);
    spi_xfer(1'b0, 7'h0C, 16'h0000, 24, 1'b1, rd);
    check("snap.new", 64'(rd), 64'h0123);

    // Aborted write after 20 bits, then a normal frame
    s0 = stb_cnt;
    spi_xfer(1'b1, 7'h01, 16'h0123, 20, 1'b1, rd);
    check("abort.stb", 64'(stb_cnt - s0), 64'd0);
    check_outputs("abort");
    s0 = stb_cnt;
    spi_xfer(1'b1, 7'h01, 16'h0456, 24, 1'b1, rd);
    model_write('h01, 'h0456);
    check("after_abort.stb", 64'(stb_cnt - s0), 64'd1);
    check_outputs("after_abort");

    // Reset in the middle of a read frame
    spi_xfer(1'b0, 7'h01, 16'h0000, 12, 1'b0, rd);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check("midrst.miso", 64'(spi_if.MISO), 64'd0);
    check("midrst.wr_stb", 64'(wr_stb), 64'd0);
    check_outputs("midrst");
    spi_if.SSEL = 1'b1; spi_if.SCK = 1'b0;
    half();
    rst = 1'b0;
    half(); half();
    spi_xfer(1'b0, 7'h7F, 16'h0000, 24, 1'b1, rd);
    check("postrst.id", 64'(rd), 64'h04A1);
    spi_xfer(1'b0, 7'h10, 16'h0000, 24, 1'b1, rd);
    check("postrst.sat2", 64'(rd), 64'h0003);

    // 30-bit frame: exactly one write of the first 24 bits
    s0 = stb_cnt;
    spi_xfer(1'b1, 7'h12, 16'h02AA, 30, 1'b1, rd);
    model_write('h12, 'h02AA);
    check("long.stb", 64'(stb_cnt - s0), 64'd1);
    check_outputs("long");

    // Randomised frames against the model
    for (int it = 0; it < 40; it++) begin
      logic        w;
      logic [6:0]  a;
      logic [15:0] d;
      int          nb;
      iffreq   = NCH*DOP_W'({$urandom, $urandom});
      pwmvalue = NCH*PWM_W'({$urandom, $urandom});
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 7'($urandom);
      else a = {4'($urandom_range(0, NCH-1)), 3'($urandom_range(0, 5))};
      d = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       nb = $urandom_range(1, 23);
        1:       nb = $urandom_range(25, 30);
        default: nb = 24;
      endcase
      s0 = stb_cnt;
      spi_xfer(w, a, d, nb, 1'b1, rd);
      if (nb >= 24 && !w)
        check($sformatf("rnd%0d.rd a=%0h", it, a), 64'(rd), 64'(model_read(int'(a))));
      if (nb >= 24 && w) model_write(int'(a), int'(d));
      check($sformatf("rnd%0d.stb", it), 64'(stb_cnt - s0), 64'((nb >= 24 && w) ? 1 : 0));
      check_outputs($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
